// File: rtl/input_packer.sv
// ---------------------------------------------------------------------------
// input_packer
//
// Packs activation beats into 32-bit bit-brick words for the fusion unit.
// Every 2-bit slice of an activation is replicated four times into one byte
// of the output word. One word is built from 1, 2 or 4 beats, depending on
// the activation width.
//
//   mode (in_bitwidth)   beats/word   bytes filled per beat
//   3'b100 (8b)          1            bytes 0..3 <- v[1:0], v[3:2], v[5:4], v[7:6]
//   3'b010 (4b)          2            beat j: bytes 2j, 2j+1 <- v[1:0], v[3:2]
//   3'b001 (2b)          4            beat j: byte j <- v[1:0]
//   any other code       treated as 8b
//
// The mode and the signed flag are captured on the first beat of a word.
// Later changes are ignored until that word completes.
//
// Ports
//   clk            clock; all state changes on its rising edge
//   RST            asynchronous, active-high reset
//   act_valid      activation beat offered
//   act_data[7:0]  activation value
//   act_ready      beat accepted when act_valid && act_ready
//   in_bitwidth    mode code, sampled on the first beat of a word
//   in_signed      activations are two's complement, sampled on the first beat
//   out_valid      packed word valid (output state FULL)
//   out_ready      downstream accepts the word
//   input_forward  packed bit-brick word
//   input_sign     per-slot sign flags
//   flush          (only with PACKER_FLUSH_EN) close a partial word early,
//                  padding unfilled bytes and sign bits with zeros
//   dbg_state      output state: 0 = EMPTY, 1 = FULL
//
// Optional feature macro: PACKER_FLUSH_EN. Without it, the flush port does
// not exist, and a partial word waits indefinitely for its remaining beats.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. Once valid is raised, the word or beat it
// carries stays stable until that transfer. Ready never depends on valid
// from the same interface. act_ready drops only for a beat that would
// complete a word while the output register is FULL and not being drained.
// ---------------------------------------------------------------------------
module input_packer (
  input  logic        clk,
  input  logic        RST,
  input  logic        act_valid,
  input  logic [7:0]  act_data,
  output logic        act_ready,
  input  logic [2:0]  in_bitwidth,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] input_forward,
  output logic [3:0]  input_sign,
`ifdef PACKER_FLUSH_EN
  input  logic        flush,
`endif
  output logic        dbg_state
);

  typedef enum logic [1:0] {
    MODE_8B = 2'd0,
    MODE_4B = 2'd1,
    MODE_2B = 2'd2
  } mode_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  function automatic mode_t decode_mode(input logic [2:0] bw);
    case (bw)
      3'b010:  decode_mode = MODE_4B;
      3'b001:  decode_mode = MODE_2B;
      default: decode_mode = MODE_8B;
    endcase
  endfunction

  function automatic logic [1:0] last_slot_of(input mode_t m);
    case (m)
      MODE_4B: last_slot_of = 2'd1;
      MODE_2B: last_slot_of = 2'd3;
      default: last_slot_of = 2'd0;
    endcase
  endfunction

  // Assembly side
  logic [31:0] asm_word_q;
  logic [3:0]  asm_sign_q;
  logic [1:0]  slot_q;
  mode_t       mode_q;
  logic        signed_q;

  // Output side
  out_state_t  state_q;
  logic [31:0] out_word_q;
  logic [3:0]  out_sign_q;

  // Per-cycle decode
  mode_t       cur_mode;
  logic        cur_signed;
  logic        at_last;
  logic        out_free;
  logic        accept;
  logic        flush_fire;
  logic        complete;
  logic [15:0] half_bricks;
  logic [31:0] beat_word;
  logic [3:0]  beat_sign;
  logic [31:0] word_next;
  logic [3:0]  sign_next;

  // Mode and sign come from the inputs only on the first beat of a word.
  // After that, they come from the values latched with that beat.
  always_comb begin
    cur_mode   = (slot_q == 2'd0) ? decode_mode(in_bitwidth) : mode_q;
    cur_signed = (slot_q == 2'd0) ? in_signed : signed_q;
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_free  = !out_valid || out_ready;
  assign at_last   = (slot_q == last_slot_of(cur_mode));
  assign act_ready = out_free || !at_last;
  assign accept    = act_valid && act_ready;

`ifdef PACKER_FLUSH_EN
  // A flush needs the same free output register as a completing beat.
  // It does nothing while the assembly register is empty, unless a beat is
  // accepted in the same cycle. In that case the beat goes in first.
  assign flush_fire = flush && out_free && (accept || (slot_q != 2'd0));
`else
  assign flush_fire = 1'b0;
`endif

  assign complete = (accept && at_last) || flush_fire;

  // Bricks contributed by the current beat
  always_comb begin
    half_bricks = {{4{act_data[3:2]}}, {4{act_data[1:0]}}};
    beat_word   = '0;
    beat_sign   = '0;
    case (cur_mode)
      MODE_4B: begin
        if (slot_q[0]) begin
          beat_word[31:16] = half_bricks;
          beat_sign        = 4'b1000;
        end else begin
          beat_word[15:0]  = half_bricks;
          beat_sign        = 4'b0010;
        end
      end
      MODE_2B: begin
        beat_word = {24'h0, {4{act_data[1:0]}}} << {slot_q, 3'b000};
        beat_sign = 4'b0001 << slot_q;
      end
      default: begin
        beat_word = {{4{act_data[7:6]}}, {4{act_data[5:4]}},
                     {4{act_data[3:2]}}, {4{act_data[1:0]}}};
        beat_sign = 4'b1000;
      end
    endcase
    if (!cur_signed) begin
      beat_sign = 4'b0000;
    end
  end

  assign word_next = asm_word_q | (accept ? beat_word : 32'h0);
  assign sign_next = asm_sign_q | (accept ? beat_sign : 4'h0);

  // Output FSM, assembly register and slot counter
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      asm_word_q <= '0;
      asm_sign_q <= '0;
      slot_q     <= 2'd0;
      mode_q     <= MODE_8B;
      signed_q   <= 1'b0;
      state_q    <= ST_EMPTY;
      out_word_q <= '0;
      out_sign_q <= '0;
    end else begin
      if (complete) begin
        // Hand the word over and restart assembly. The slot counter wraps.
        // If the previous word drains this cycle, FULL stays FULL with the
        // new word.
        out_word_q <= word_next;
        out_sign_q <= sign_next;
        state_q    <= ST_FULL;
        asm_word_q <= '0;
        asm_sign_q <= '0;
        slot_q     <= 2'd0;
      end else begin
        if (accept) begin
          asm_word_q <= word_next;
          asm_sign_q <= sign_next;
          slot_q     <= slot_q + 2'd1;
        end
        if (out_valid && out_ready) begin
          state_q <= ST_EMPTY;
        end
      end
      if (accept && (slot_q == 2'd0)) begin
        mode_q   <= cur_mode;
        signed_q <= cur_signed;
      end
    end
  end

  assign input_forward = out_word_q;
  assign input_sign    = out_sign_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_input_packer.sv
// ---------------------------------------------------------------------------
// tb_input_packer: self-checking bench for input_packer.
// Expected words are pushed to exp_q when the stimulus that completes them is
// driven. The monitor pops and compares each word as it is handed over.
// Define PACKER_FLUSH_EN to include the flush scenarios.
// ---------------------------------------------------------------------------
module tb_input_packer;

  logic        clk;
  logic        RST;
  logic        act_valid;
  logic [7:0]  act_data;
  logic        act_ready;
  logic [2:0]  in_bitwidth;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] input_forward;
  logic [3:0]  input_sign;
  logic        dbg_state;
`ifdef PACKER_FLUSH_EN
  logic        flush;
`endif

  int tests_run;
  int tests_failed;

  // {sign[3:0], word[31:0]}
  logic [35:0] exp_q[$];

  // Reference model state for the random section
  int          m_n;
  int          m_slot;
  logic [31:0] m_word;
  logic [3:0]  m_sign;
  logic        m_s;

  logic [2:0] bw_codes [5] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b111};

  input_packer dut (
    .clk           (clk),
    .RST           (RST),
    .act_valid     (act_valid),
    .act_data      (act_data),
    .act_ready     (act_ready),
    .in_bitwidth   (in_bitwidth),
    .in_signed     (in_signed),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .input_forward (input_forward),
    .input_sign    (input_sign),
`ifdef PACKER_FLUSH_EN
    .flush         (flush),
`endif
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Driver: present one beat and hold it until accepted. With release_bp set,
  // out_ready is forced high after two stalled cycles so that a completing
  // beat can get through.
  task automatic send_beat(input logic [7:0] d, input logic [2:0] bw, input logic s,
                           input bit release_bp);
    int n;
    n = 0;
    act_valid   = 1'b1;
    act_data    = d;
    in_bitwidth = bw;
    in_signed   = s;
    #1;
    while (!act_ready && n < 50) begin
      @(negedge clk);
      n++;
      if (release_bp && n >= 2) out_ready = 1'b1;
      #1;
    end
    if (!act_ready) begin
      check("beat_accept_timeout", 64'd0, 64'd1);
      act_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      act_valid = 1'b0;
    end
  endtask

  task automatic push_exp(input logic [3:0] s, input logic [31:0] w);
    exp_q.push_back({s, w});
  endtask

  // Independent reference model: builds each word byte by byte from the
  // beats. The word is pushed when the beat that completes it is driven.
  task automatic model_beat(input logic [7:0] v, input logic [2:0] bw, input logic s);
    if (m_slot == 0) begin
      case (bw)
        3'b010:  m_n = 2;
        3'b001:  m_n = 4;
        default: m_n = 1;
      endcase
      m_s = s;
    end
    if (m_n == 1) begin
      for (int k = 0; k < 4; k++) m_word[8*k +: 8] = {4{v[2*k +: 2]}};
      m_sign[3] = m_s;
    end else if (m_n == 2) begin
      for (int mm = 0; mm < 2; mm++) m_word[8*(2*m_slot+mm) +: 8] = {4{v[2*mm +: 2]}};
      m_sign[2*m_slot+1] = m_s;
    end else begin
      m_word[8*m_slot +: 8] = {4{v[1:0]}};
      m_sign[m_slot] = m_s;
    end
    m_slot++;
    if (m_slot == m_n) begin
      push_exp(m_sign, m_word);
      m_slot = 0;
      m_word = '0;
      m_sign = '0;
    end
  endtask

  // Scoreboard monitor: samples well away from the rising edge
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!RST && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(input_forward), 64'hdead);
        end else begin
          e = exp_q.pop_front();
          check("word", 64'(input_forward), 64'(e[31:0]));
          check("sign", 64'(input_sign), 64'(e[35:32]));
        end
      end
    end
  end

  // Main sequence
  initial begin
    logic [7:0] d;
    logic [2:0] bw;
    logic       s;
    logic [7:0] next_vals [3];

    tests_run = 0;
    tests_failed = 0;
    m_n = 1; m_slot = 0; m_word = '0; m_sign = '0; m_s = 1'b0;
    RST = 1'b1;
    act_valid = 1'b0;
    act_data = 8'h0;
    in_bitwidth = 3'b100;
    in_signed = 1'b0;
    out_ready = 1'b1;
`ifdef PACKER_FLUSH_EN
    flush = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_word", 64'(input_forward), 64'd0);
    check("rst_sign", 64'(input_sign), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    RST = 1'b0;
    @(negedge clk);
    #1;
    check("ready_after_rst", 64'(act_ready), 64'd1);

    // 8b unsigned: each word appears one cycle after its beat
    push_exp(4'h0, 32'h000000ff);
    send_beat(8'd3, 3'b100, 1'b0, 1'b0);
    check("lat_8b_a", 64'(out_valid), 64'd1);
    check("state_full", 64'(dbg_state), 64'd1);
    push_exp(4'h0, 32'h0000ff55);
    send_beat(8'd13, 3'b100, 1'b0, 1'b0);
    check("lat_8b_b", 64'(out_valid), 64'd1);

    // 8b signed, back to back
    push_exp(4'h8, 32'haa000000);
    send_beat(8'h80, 3'b100, 1'b1, 1'b0);
    push_exp(4'h8, 32'h55ffffff);
    send_beat(8'h7f, 3'b100, 1'b1, 1'b0);
    push_exp(4'h8, 32'hffffaaaa);
    send_beat(8'hfa, 3'b100, 1'b1, 1'b0);
    check("lat_8b_s", 64'(out_valid), 64'd1);

    // 4b signed. The mode/sign inputs change on the second beat and must be ignored.
    send_beat(8'h3, 3'b010, 1'b1, 1'b0);
    check("4b_partial_valid", 64'(out_valid), 64'd0);
    push_exp(4'b1010, 32'hff5500ff);
    send_beat(8'hD, 3'b100, 1'b0, 1'b0);
    check("lat_4b", 64'(out_valid), 64'd1);

    // 2b with downstream stall: word held, only the completing beat stalls
    send_beat(8'd1, 3'b001, 1'b0, 1'b0);
    send_beat(8'd2, 3'b001, 1'b0, 1'b0);
    send_beat(8'd3, 3'b001, 1'b0, 1'b0);
    out_ready = 1'b0;
    push_exp(4'h0, 32'h00ffaa55);
    send_beat(8'd0, 3'b001, 1'b0, 1'b0);
    check("lat_2b", 64'(out_valid), 64'd1);
    next_vals[0] = 8'd2;
    next_vals[1] = 8'd3;
    next_vals[2] = 8'd1;
    for (int i = 0; i < 3; i++) begin
      check("hold_word", 64'(input_forward), 64'h00ffaa55);
      check("hold_valid", 64'(out_valid), 64'd1);
      send_beat(next_vals[i], 3'b001, 1'b0, 1'b0);
    end
    act_valid = 1'b1;
    act_data = 8'd0;
    in_bitwidth = 3'b001;
    #1;
    check("bp_ready_0", 64'(act_ready), 64'd0);
    check("hold_word_bp", 64'(input_forward), 64'h00ffaa55);
    check("hold_sign_bp", 64'(input_sign), 64'h0);
    @(negedge clk);
    #1;
    check("bp_ready_1", 64'(act_ready), 64'd0);
    @(negedge clk);
    push_exp(4'h0, 32'h0055ffaa);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(act_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    act_valid = 1'b0;
    check("full_to_full", 64'(out_valid), 64'd1);
    check("full_to_full_word", 64'(input_forward), 64'h0055ffaa);

    // Reset mid-word in 2b mode discards the partial word
    send_beat(8'd1, 3'b001, 1'b0, 1'b0);
    send_beat(8'd2, 3'b001, 1'b0, 1'b0);
    #3;
    RST = 1'b1;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_word", 64'(input_forward), 64'd0);
    @(negedge clk);
    RST = 1'b0;
    push_exp(4'h0, 32'h000000ff);
    send_beat(8'd3, 3'b100, 1'b0, 1'b0);
    check("post_rst_lat", 64'(out_valid), 64'd1);
    @(negedge clk);

    // Reset while a word is held: that word is never emitted
    out_ready = 1'b0;
    send_beat(8'h55, 3'b100, 1'b0, 1'b0);
    check("held_valid", 64'(out_valid), 64'd1);
    check("held_word", 64'(input_forward), 64'h55555555);
    #3;
    RST = 1'b1;
    #1;
    check("rst_held_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    RST = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("no_held_emit", 64'(out_valid), 64'd0);
    @(negedge clk);

`ifdef PACKER_FLUSH_EN
    // Flush closes a partial 2b word
    send_beat(8'd3, 3'b001, 1'b1, 1'b0);
    send_beat(8'd1, 3'b001, 1'b1, 1'b0);
    push_exp(4'b0011, 32'h000055ff);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd1);
    check("flush_word", 64'(input_forward), 64'h000055ff);
    // Flush with nothing assembled does nothing
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_noop", 64'(out_valid), 64'd0);
    @(negedge clk);
    // Flush together with a first beat: the beat goes in first
    push_exp(4'b0001, 32'h000000aa);
    flush = 1'b1;
    send_beat(8'd2, 3'b001, 1'b1, 1'b0);
    flush = 1'b0;
    check("flush_beat_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
`endif

    // Random beats, modes and downstream stalls, checked against the model
    for (int i = 0; i < 120; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom_range(0, 255));
      bw = bw_codes[$urandom_range(0, 4)];
      s  = 1'($urandom_range(0, 1));
      model_beat(d, bw, s);
      send_beat(d, bw, s, 1'b1);
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end

    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/input_packer.md
INPUT_PACKER -- requirements
Module: input_packer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port act_valid, input, 1 bit: an activation beat is offered.
REQ-004 SHALL have port act_data, input, 8 bits: activation value; only the low 8, 4 or 2 bits are used, per mode.
REQ-005 SHALL have port act_ready, output, 1 bit: the beat is accepted when act_valid and act_ready are both high.
REQ-006 SHALL have port in_bitwidth, input, 3 bits: mode; 3'b100 = 8b, 3'b010 = 4b, 3'b001 = 2b; any other code = 8b.
REQ-007 SHALL have port in_signed, input, 1 bit: activations are two's complement.
REQ-008 SHALL have port out_valid, output, 1 bit: the packed word is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream fusion unit accepts the word.
REQ-010 SHALL have port input_forward, output, 32 bits: packed bit-brick word.
REQ-011 SHALL have port input_sign, output, 4 bits: per-slot sign flags.
REQ-012 SHALL have port flush, input, 1 bit: present only when PACKER_FLUSH_EN is defined.

Function
REQ-013 SHALL pack a word from 1, 2 or 4 accepted beats in 8b, 4b or 2b mode respectively.
REQ-014 8b mode: byte k of input_forward (k = 0..3) SHALL be the 2-bit slice act[2k+1:2k] replicated 4 times; input_sign SHALL be 4'b1000 if signed, else 0.
REQ-015 4b mode: the j-th beat (j = 0,1) SHALL fill bytes 2j+m (m = 0,1) with {4{v[2m+1:2m]}}; sign bit 2j+1 SHALL be set if signed.
REQ-016 2b mode: the j-th beat (j = 0..3) SHALL fill byte j with {4{v[1:0]}}; sign bit j SHALL be set if signed.
REQ-017 in_bitwidth and in_signed SHALL be sampled on the first beat of a word and held for that word; changes while a word is partially assembled SHALL be ignored until it completes.
REQ-018 Beats SHALL be collected in an assembly register with a slot counter; the completed word SHALL move to a separate output register.
REQ-019 Latency: out_valid SHALL rise in the cycle after the completing beat is accepted.
REQ-020 input_forward and input_sign SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 Output states SHALL be EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY->FULL on word completion.
  - FULL->EMPTY on out_ready with no completion that cycle.
  - FULL->FULL with the new word when out_ready and completion coincide.
REQ-022 act_ready SHALL equal (!out_valid || out_ready) || (slot counter not at last slot); only a completing beat is back-pressured.
REQ-023 Sustained throughput SHALL be one beat per cycle with out_ready held high.
REQ-024 The slot counter SHALL wrap to 0 after the last slot of the mode.

Reset
REQ-025 RST=1 SHALL immediately clear out_valid, input_forward, input_sign, the assembly register, the slot counter and the latched mode.
REQ-026 act_ready SHALL be 1 from the first clock edge after RST deasserts.
REQ-027 Reset mid-word SHALL discard partial and held words; no word SHALL be emitted for them.

Configuration
REQ-028 With PACKER_FLUSH_EN defined, flush=1 with a nonzero slot count SHALL complete the word with unfilled bytes 0x00 and unfilled sign bits 0.
REQ-029 With PACKER_FLUSH_EN defined, flush with a zero slot count SHALL be a no-op.
REQ-030 With PACKER_FLUSH_EN defined, flush coincident with an accepted beat SHALL include that beat first.
REQ-031 With PACKER_FLUSH_EN defined, flush SHALL be subject to the same back-pressure as a completing beat.
REQ-032 Without PACKER_FLUSH_EN, the flush port SHALL be absent and partial words SHALL be held indefinitely.

Verification
REQ-033 Bench SHALL cover 8b, unsigned: beats 3, then 13 -> words 0x000000ff then 0x0000ff55, input_sign 0, each one cycle after its beat.
REQ-034 Bench SHALL cover 8b, signed: beats 0x80, 0x7f, 0xfa -> words 0xaa000000, 0x55ffffff, 0xffffaaaa, input_sign 4'h8 on each.
REQ-035 Bench SHALL cover 4b, signed: beats 0x3, then 0xD -> one word 0xff5500ff, input_sign 4'b1010; out_valid stays 0 after the first beat.
REQ-036 Bench SHALL cover 2b: beats 1, 2, 3, 0 -> word 0x00ffaa55; out_ready=0 for 3 cycles holds the word stable and drops act_ready only on the next completing beat.
REQ-037 Bench SHALL cover reset after 2 of 4 beats in 2b mode -> no word emitted; the next 8b beat 3 -> 0x000000ff.
REQ-038 Bench SHALL cover, with PACKER_FLUSH_EN, 2b beats 3, 1 then flush -> word 0x000055ff, input_sign 4'b0011 if signed.
